// File: rtl/pid_pkg.sv
// Shared defaults and helpers for the pid_param controller slice.
package pid_pkg;

    localparam int DEF_ERR_W    = 13;
    localparam int DEF_OUT_W    = 12;
    localparam int DEF_INT_W    = 18;
    localparam int DEF_D_DEPTH  = 3;
    localparam int DEF_D_SAT_W  = 9;
    localparam int DEF_KD_SHIFT = 1;

    // Decimator: full period uses all DEC_W bits, FAST_SIM only the low bits.
    localparam int DEC_W      = 20;
    localparam int DEC_FAST_W = 15;

    // Largest / smallest value of a w-bit two's complement number.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int DEF_D_SAT_MAX = sat_max(DEF_D_SAT_W);
    localparam int DEF_D_SAT_MIN = sat_min(DEF_D_SAT_W);

endpackage

// File: rtl/pid_sat.sv
// Signed saturation from IN_W bits down to OUT_W bits.
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W  = DEF_ERR_W,
    parameter int OUT_W = DEF_D_SAT_W
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] LO = IN_W'(sat_min(OUT_W));

    // Clamp to the representable OUT_W range, otherwise pass the low bits.
    always_comb begin
        out_o = in_i[OUT_W-1:0];
        if (in_i > HI) begin
            out_o = HI[OUT_W-1:0];
        end else if (in_i < LO) begin
            out_o = LO[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pid_param.sv
// Decimated PID drive: P + I + D, clipped to an unsigned OUT_W magnitude.
module pid_param
    import pid_pkg::*;
#(
    parameter int ERR_W    = DEF_ERR_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int INT_W    = DEF_INT_W,
    parameter int D_DEPTH  = DEF_D_DEPTH,
    parameter int D_SAT_W  = DEF_D_SAT_W,
    parameter int KD_SHIFT = DEF_KD_SHIFT,
    parameter int FAST_SIM = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    not_pedaling,
    input  logic                    freeze_int,
    output logic [OUT_W-1:0]        drv_mag,
    output logic                    drv_vld
);

    localparam int SUM_W = ERR_W + 2;
    localparam logic signed [SUM_W-1:0] MAG_MAX = SUM_W'((1 << OUT_W) - 1);

    logic [DEC_W-1:0]        dec_q;
    logic                    tick;
    logic [INT_W-1:0]        int_q, int_d, int_sum;
    logic signed [ERR_W-1:0] hist_q [D_DEPTH];
    logic signed [ERR_W-1:0] d_diff;
    logic signed [D_SAT_W-1:0] d_sat;
    logic signed [SUM_W-1:0] p_d, i_d, d_d;
    logic signed [SUM_W-1:0] p_q, i_q, d_q;
    logic signed [SUM_W-1:0] sum;
    logic [OUT_W-1:0]        mag_d, mag_q;
    logic [1:0]              vld_q;

    assign tick = (FAST_SIM != 0) ? (&dec_q[DEC_FAST_W-1:0]) : (&dec_q);

    // Free-running decimator, wraps naturally after all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_q <= '0;
        else        dec_q <= dec_q + DEC_W'(1);
    end

    // Integrator next state: clear beats hold beats tick; sum clamps to [0, max].
    // The integrator is never negative, so a set sign bit means either the sum
    // went below zero (bit INT_W-2 clear) or overflowed upward (bit INT_W-2 set).
    always_comb begin
        int_sum = int_q + INT_W'(error);
        int_d   = int_q;
        if (not_pedaling) begin
            int_d = '0;
        end else if (!freeze_int && tick) begin
            if (int_sum[INT_W-1]) int_d = int_q[INT_W-2] ? {1'b0, {(INT_W-1){1'b1}}} : '0;
            else                  int_d = int_sum;
        end
    end

    // Integrator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_q <= '0;
        else        int_q <= int_d;
    end

    // Error history, shifted on each tick; the last entry is the oldest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
        end else if (tick) begin
            hist_q[0] <= error;
            for (int unsigned k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    assign d_diff = error - hist_q[D_DEPTH-1];

    pid_sat #(
        .IN_W  (ERR_W),
        .OUT_W (D_SAT_W)
    ) u_dsat (
        .in_i  (d_diff),
        .out_o (d_sat)
    );

    // Term formation at the common sum width.
    always_comb begin
        p_d = SUM_W'(error);
        i_d = SUM_W'(int_q[INT_W-2 -: OUT_W]);
        d_d = SUM_W'(d_sat) <<< KD_SHIFT;
    end

    // Stage 1: register the three terms every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            i_q <= '0;
            d_q <= '0;
        end else begin
            p_q <= p_d;
            i_q <= i_d;
            d_q <= d_d;
        end
    end

    // Sum and clip to the unsigned drive range.
    always_comb begin
        sum = p_q + i_q + d_q;
        if (sum[SUM_W-1])     mag_d = '0;
        else if (sum > MAG_MAX) mag_d = '1;
        else                  mag_d = sum[OUT_W-1:0];
    end

    // Stage 2 result register and tick-aligned valid shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            vld_q <= '0;
        end else begin
            mag_q <= mag_d;
            vld_q <= {vld_q[0], tick};
        end
    end

    assign drv_mag = mag_q;
    assign drv_vld = vld_q[1];

endmodule

// File: tb/tb_pid_param.sv
// Self-checking bench for pid_param (defaults, FAST_SIM=1).
module tb_pid_param;

    localparam int ERR_W   = 13;
    localparam int D_DEPTH = 3;
    localparam int PERIOD  = 32768;
    localparam int INT_MAX = 131071;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic signed [ERR_W-1:0] err;
    logic                    np;
    logic                    fr;
    logic [11:0]             drv_mag;
    logic                    drv_vld;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: decimator count, integrator, error history, 2-deep output delay.
    int m_cnt;
    int m_int;
    int m_hist[$];
    int m_prev_res;
    int m_prev_tick;

    typedef struct {
        int e;
        bit np;
        bit fr;
        int mag;
    } vec_t;

    vec_t vt[14];

    always #5 clk = ~clk;

    pid_param #(
        .ERR_W    (13),
        .OUT_W    (12),
        .INT_W    (18),
        .D_DEPTH  (3),
        .D_SAT_W  (9),
        .KD_SHIFT (1),
        .FAST_SIM (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .error        (err),
        .not_pedaling (np),
        .freeze_int   (fr),
        .drv_mag      (drv_mag),
        .drv_vld      (drv_vld)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_int = 0;
        m_hist.delete();
        for (int k = 0; k < D_DEPTH; k++) m_hist.push_back(0);
        m_prev_res  = 0;
        m_prev_tick = 0;
    endtask

    function automatic bit tick_now();
        return (m_cnt % PERIOD) == PERIOD - 1;
    endfunction

    // Evaluate one cycle of the specification with the inputs currently applied.
    task automatic model_cycle(output int res, output int tk);
        int e, d, s;
        e  = int'(err);
        tk = tick_now() ? 1 : 0;
        d  = (e - m_hist[D_DEPTH-1]) & 8191;
        if (d >= 4096) d -= 8192;
        if (d > 255)  d = 255;
        if (d < -256) d = -256;
        s   = e + (m_int / 32) + 2 * d;
        res = (s < 0) ? 0 : ((s > 4095) ? 4095 : s);
        if (np) begin
            m_int = 0;
        end else if (!fr && tk != 0) begin
            m_int = m_int + e;
            if (m_int < 0)       m_int = 0;
            if (m_int > INT_MAX) m_int = INT_MAX;
        end
        if (tk != 0) begin
            m_hist.push_front(e);
            void'(m_hist.pop_back());
        end
        m_cnt = (m_cnt + 1) % (1 << 20);
    endtask

    // Advance one clock and compare both outputs with the model.
    task automatic step();
        int res, tk, exp_m, exp_v;
        model_cycle(res, tk);
        exp_m       = m_prev_res;
        exp_v       = m_prev_tick;
        m_prev_res  = res;
        m_prev_tick = tk;
        @(posedge clk);
        #1;
        check("model_mag", int'(drv_mag), exp_m);
        check("model_vld", int'(drv_vld), exp_v);
    endtask

    task automatic rand_inputs();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      err = 13'sd4095;
        else if (sel == 1) err = -13'sd4096;
        else               err = ERR_W'($urandom);
        np = ($urandom_range(0, 63) == 0);
        fr = ($urandom_range(0, 7) == 0);
    endtask

    task automatic wait_tick(input string name);
        int g;
        g = 0;
        while (!tick_now() && g < 64) begin
            step();
            g++;
        end
        if (g >= 64) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no tick within 64 cycles, model count %0d", name, m_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vt[0]  = '{100,   0, 0, 300};
        vt[1]  = '{4095,  0, 0, 4095};
        vt[2]  = '{-4096, 0, 0, 0};
        vt[3]  = '{0,     0, 0, 0};
        vt[4]  = '{50,    1, 0, 150};
        vt[5]  = '{1000,  0, 1, 1510};
        vt[6]  = '{127,   0, 0, 381};
        vt[7]  = '{128,   0, 0, 384};
        vt[8]  = '{255,   1, 1, 765};
        vt[9]  = '{256,   0, 0, 766};
        vt[10] = '{-1,    0, 0, 0};
        vt[11] = '{2000,  0, 0, 2510};
        vt[12] = '{3584,  0, 0, 4094};
        vt[13] = '{3586,  0, 0, 4095};

        rst_n = 1'b0;
        err   = '0;
        np    = 1'b0;
        fr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mag", int'(drv_mag), 0);
        check("reset_vld", int'(drv_vld), 0);
        rst_n = 1'b1;
        model_reset();

        // No tick yet: integrator and history are zero, result is P + 2*sat(error).
        for (int i = 0; i < 14; i++) begin
            err = ERR_W'(vt[i].e);
            np  = vt[i].np;
            fr  = vt[i].fr;
            step();
            step();
            check("vec_mag", int'(drv_mag), vt[i].mag);
            check("vec_vld", int'(drv_vld), 0);
        end

        while (m_cnt < PERIOD - 8) begin
            rand_inputs();
            step();
        end

        // First tick with error 300 held: integrator becomes 300 (I term 9).
        err = 13'sd300;
        np  = 1'b0;
        fr  = 1'b0;
        wait_tick("tick1_wait");
        step();
        step();
        check("tick1_vld", int'(drv_vld), 1);
        check("tick1_mag_pre", int'(drv_mag), 810);
        step();
        check("tick1_vld_once", int'(drv_vld), 0);
        check("tick1_mag_post", int'(drv_mag), 819);

        fr = 1'b1;
        repeat (10) step();
        fr  = 1'b0;
        err = '0;
        step();
        step();
        check("integ_held", int'(drv_mag), 9);
        np = 1'b1;
        step();
        np = 1'b0;
        step();
        check("np_pre", int'(drv_mag), 9);
        step();
        check("np_clear", int'(drv_mag), 0);

        while (m_cnt < 2 * PERIOD - 8) begin
            rand_inputs();
            step();
        end

        // Reset one cycle after the second tick must discard the pending strobe.
        err = 13'sd1000;
        np  = 1'b0;
        fr  = 1'b0;
        wait_tick("tick2_wait");
        step();
        rst_n = 1'b0;
        #1;
        check("rst_async_mag", int'(drv_mag), 0);
        check("rst_async_vld", int'(drv_vld), 0);
        @(posedge clk);
        #1;
        check("rst_no_vld", int'(drv_vld), 0);
        check("rst_mag", int'(drv_mag), 0);
        rst_n = 1'b1;
        model_reset();

        err = 13'sd100;
        step();
        step();
        check("post_rst_mag", int'(drv_mag), 300);
        check("post_rst_vld", int'(drv_vld), 0);

        repeat (300) begin
            rand_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pid_param.md
PID_PARAM -- requirements
Module: pid_param

Interface
REQ-001 SHALL have parameter ERR_W, default 13, signed error width.
REQ-002 SHALL have parameter OUT_W, default 12, unsigned drive-magnitude width.
REQ-003 SHALL have parameter INT_W, default 18, integrator width.
REQ-004 SHALL have parameter D_DEPTH, default 3, error-history depth, legal range 1..8.
REQ-005 SHALL have parameter D_SAT_W, default 9, saturated derivative width.
REQ-006 SHALL have parameter KD_SHIFT, default 1, derivative gain as a left shift.
REQ-007 SHALL have parameter FAST_SIM, default 0; 1 selects the short decimation period.
REQ-008 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port error, input, ERR_W, signed error sample.
REQ-011 SHALL have port not_pedaling, input, 1, integrator clear request.
REQ-012 SHALL have port freeze_int, input, 1, integrator hold request.
REQ-013 SHALL have port drv_mag, output, OUT_W, registered clipped PID result.
REQ-014 SHALL have port drv_vld, output, 1, one-cycle strobe marking the first result computed after a tick.

Function
REQ-015 SHALL run a free-running 20-bit decimator; tick = all-ones of bits [19:0], or of bits [14:0] when FAST_SIM=1; the counter wraps to 0 after all-ones.
REQ-016 On tick, integrator SHALL load sign-extended error + integrator; a negative sum loads 0; a sum with sign bit set while integrator bit INT_W-2 is set loads 2^(INT_W-1)-1.
REQ-017 not_pedaling=1 SHALL load integrator 0 on every cycle, overriding tick and freeze_int.
REQ-018 freeze_int=1 with not_pedaling=0 SHALL hold the integrator across ticks.
REQ-019 On tick, a D_DEPTH-entry history shift register SHALL shift in error; the oldest entry is prev_err.
REQ-020 D_diff SHALL be error - prev_err at ERR_W bits, saturated to D_SAT_W signed (max 2^(D_SAT_W-1)-1, min -2^(D_SAT_W-1)), then shifted left KD_SHIFT.
REQ-021 P term SHALL be error sign-extended; I term SHALL be integrator[INT_W-2 -: OUT_W] zero-extended.
REQ-022 Stage 1 SHALL register P, I (current integrator, pre-update) and D every cycle; stage 2 SHALL register the clipped sum into drv_mag: negative -> 0, above 2^OUT_W-1 -> all ones.
REQ-023 drv_mag latency SHALL be 2 cycles from error/integrator change.
REQ-024 drv_vld SHALL pulse high exactly 2 cycles after each tick, via a 2-bit valid shift register.
REQ-025 Intermediate sum width SHALL be ERR_W+2 bits so no term combination overflows before clipping.

Reset
REQ-026 rst_n low SHALL asynchronously clear decimator, integrator, history, stage-1 registers, drv_mag (0) and drv_vld (0).
REQ-027 Reset asserted mid-pipeline SHALL discard in-flight results; no drv_vld is issued for a tick preceding reset.
REQ-028 After reset release, the first tick SHALL occur 2^20 cycles later (2^15 with FAST_SIM).

Structure
REQ-029 Default widths, decimator widths and saturation limits SHALL live in shared package pid_pkg.
REQ-030 Signed saturation SHALL be a sub-module pid_sat (parameters IN_W, OUT_W) instantiated for D_diff.
REQ-031 Implementation SHALL be 120-400 lines of RTL, all registers in a single clock domain.

Verification (defaults, FAST_SIM=1)
REQ-032 Reset, error=100 held, no tick yet -> drv_mag=300 (P 100 + D 200) two cycles later, drv_vld=0.
REQ-033 error=100 held through 3 ticks -> integrator=300, D=0, drv_mag=109, drv_vld pulses 2 cycles after each tick.
REQ-034 error=4095 -> D saturates to 255 (term 510), drv_mag=0xFFF; repeated ticks -> integrator sticks at 0x1FFFF.
REQ-035 error=-4096 -> drv_mag=0; integrator never goes below 0.
REQ-036 Integrator at 300, not_pedaling=1 for 1 cycle -> integrator=0 next cycle; freeze_int=1 across a tick -> integrator unchanged.
REQ-037 rst_n pulsed low 1 cycle after a tick -> drv_mag=0, no drv_vld, decimator restarts from 0.
